// File: rtl/ahb_slave_mem.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ahb_slave_mem
// Description : AHB-Lite slave with an internal word-addressed register file.
//               Accepts NONSEQ/SEQ transfers and decodes a DEPTH*4-byte
//               window at BASE_ADDR. Inserts WAIT_STATES wait cycles per
//               OKAY data phase. Writes land on the edge that ends the
//               final data-phase cycle. Reads are driven combinationally
//               during that cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   BASE_ADDR   : window base address, aligned to DEPTH*4
//   DEPTH       : number of 32-bit words (power of two)
//   WAIT_STATES : wait cycles inserted before each OKAY data phase (0..7)
// Ports
//   Hclk        in   clock, rising edge
//   Hreset      in   synchronous active-high reset
//   Hreadyin    in   bus HREADY; the address phase is sampled only when high
//   Htrans[1:0] in   IDLE/BUSY/NONSEQ/SEQ
//   Hwrite      in   1 = write
//   Haddr[31:0] in   byte address (bits [1:0] ignored)
//   Hwdata[31:0]in   write data (data phase)
//   Hreadyout   out  slave ready (registered)
//   Hresp[1:0]  out  00 OKAY / 01 ERROR (registered)
//   Hrdata[31:0]out  read data during the final data-phase cycle, else 0
// Build option
//   AHB_SLV_ERR_EN : when defined, out-of-window accesses get the two-cycle
//                    ERROR response. Otherwise they get a zero-wait OKAY,
//                    writes are dropped and reads return 0.
// ============================================================================
module ahb_slave_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH       = 32,
    parameter int          WAIT_STATES = 0
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic        Hwrite,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    output logic        Hreadyout,
    output logic [1:0]  Hresp,
    output logic [31:0] Hrdata
);

    localparam int         c_IDX_W   = $clog2(DEPTH);
    localparam logic [2:0] c_WS_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    state_t               w_acc_state;
    logic [2:0]           r_cnt;
    logic [2:0]           w_cnt_next;
    logic                 r_hreadyout;
    logic                 r_write;
    logic                 r_hit;
    logic [c_IDX_W-1:0]   r_idx;
    logic [31:0]          r_mem [DEPTH];

    logic                 w_accept;
    logic                 w_hit;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_unused;

    // Only NONSEQ/SEQ (Htrans[1]) are real transfers; byte lanes are not
    // supported, so the low address bits and Htrans[0] carry no information.
    assign w_accept = Hreadyin & r_hreadyout & Htrans[1];
    assign w_hit    = (Haddr[31:c_IDX_W+2] == BASE_ADDR[31:c_IDX_W+2]);
    assign w_idx    = Haddr[c_IDX_W+1:2];
    assign w_unused = ^{Haddr[1:0], Htrans[0]};

    // Next-state and wait-counter logic.
    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        w_acc_state = ST_DATA;

        if (w_hit) begin
            if (WAIT_STATES > 0) begin
                w_acc_state = ST_WAIT;
            end else begin
                w_acc_state = ST_DATA;
            end
        end else begin
`ifdef AHB_SLV_ERR_EN
            w_acc_state = ST_ERR1;
`else
            w_acc_state = ST_DATA;
`endif
        end

        case (r_state)
            ST_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_next = ST_DATA;
                end else begin
                    w_cnt_next = r_cnt - 3'd1;
                end
            end
            ST_ERR1: begin
                w_next = ST_ERR2;
            end
            default: begin
                // IDLE, DATA and ERR2 all present Hreadyout=1, so a new
                // address phase can be taken here without a bubble.
                w_next = ST_IDLE;
                if (w_accept) begin
                    w_next     = w_acc_state;
                    w_cnt_next = c_WS_INIT;
                end
            end
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_hreadyout <= 1'b1;
            r_write     <= 1'b0;
            r_hit       <= 1'b0;
            r_idx       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            // Ready is registered from the next state so it is glitch-free.
            r_hreadyout <= (w_next != ST_WAIT) && (w_next != ST_ERR1);
            if (w_accept) begin
                r_write <= Hwrite;
                r_hit   <= w_hit;
                r_idx   <= w_idx;
            end
            if ((r_state == ST_DATA) && r_write && r_hit) begin
                r_mem[r_idx] <= Hwdata;
            end
        end
    end

`ifdef AHB_SLV_ERR_EN
    logic [1:0] r_hresp;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_hresp <= 2'b00;
        end else begin
            r_hresp <= ((w_next == ST_ERR1) || (w_next == ST_ERR2)) ? 2'b01 : 2'b00;
        end
    end

    assign Hresp = r_hresp;
`else
    assign Hresp = 2'b00;
`endif

    assign Hreadyout = r_hreadyout;
    // Out-of-window reads return zero; the index is meaningless for them.
    assign Hrdata    = ((r_state == ST_DATA) && r_hit) ? r_mem[r_idx] : 32'h0;

endmodule
`default_nettype wire

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

AHB-Lite slave responder with an internal word-addressed register file. It is the bus-side counterpart to `ahb_master`: it accepts NONSEQ/SEQ transfers, decodes the address window, and inserts a programmable number of wait states. It stores write data and returns read data with OKAY/ERROR responses. It is the target the bridge and master benches run against.

## Interface
- `BASE_ADDR`, 32'h8000_0000: window base; must be aligned to `DEPTH*4`.
- `DEPTH`, 32: number of 32-bit words; power of two; `IDX_W = log2(DEPTH)`.
- `WAIT_STATES`, 0: wait cycles per OKAY data phase; legal range 0..7.

Ports:
- `Hclk` in, 1: clock; all logic on the rising edge.
- `Hreset` in, 1: reset; synchronous, active-high.
- `Hreadyin` in, 1: bus HREADY; the address phase is sampled only when high.
- `Htrans` in, 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `Hwrite` in, 1: 1 = write, 0 = read.
- `Haddr` in, 32: byte address.
- `Hwdata` in, 32: write data, valid in the data phase.
- `Hreadyout` out, 1: slave ready; low extends the data phase.
- `Hresp` out, 2: 00 OKAY, 01 ERROR.
- `Hrdata` out, 32: read data, valid when `Hreadyout`=1 in a read data phase.

## Operation
- **Accept condition:** `Hreadyin`=1 && `Hreadyout`=1 && `Htrans[1]`=1. On accept, latch `Hwrite`, the hit flag, and index `Haddr[IDX_W+1:2]`. `Haddr[1:0]` is ignored; all accesses are full-word.
- **Hit:** `Haddr[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]`.
- IDLE and BUSY transfers are never accepted. They get a zero-wait OKAY.
- **FSM states:**
  - IDLE: no data phase pending.
  - WAIT: wait counter running; `Hreadyout`=0.
  - DATA: final OKAY data-phase cycle; `Hreadyout`=1.
  - ERR1: first ERROR cycle; `Hreadyout`=0, `Hresp`=01.
  - ERR2: second ERROR cycle; `Hreadyout`=1, `Hresp`=01.
- **Transitions:**
  - Accept of a hit: go to WAIT (counter = `WAIT_STATES`-1) if `WAIT_STATES`>0, else to DATA.
  - Accept of a miss: go to ERR1, then ERR2.
  - WAIT: go to DATA when the counter reaches 0.
  - DATA/ERR2: go to IDLE, or take the next state directly if a new transfer is accepted in the same cycle (pipelined back-to-back).
  - IDLE: `Hreadyout`=1, `Hresp`=00.
- **Write:** `mem[idx_q] <= Hwdata` on the rising edge that ends the DATA cycle.
- **Read:** `Hrdata` = `mem[idx_q]` combinationally during DATA; 0 in all other states.
  - A read whose address phase overlaps a write's DATA cycle to the same word returns the new data.
- **Reset:** state IDLE; `Hreadyout`=1; `Hresp`=00; `Hrdata`=0; all `mem` words 0; latched phase info cleared.
  - Reset asserted mid data phase aborts the transfer; no memory write occurs on that edge.

## Timing
- Address phase in cycle N, hit: DATA in cycle N+1+`WAIT_STATES`.
- `Hreadyout` is low for exactly `WAIT_STATES` cycles (N+1 .. N+`WAIT_STATES`).
- Miss: ERR1 in N+1, ERR2 in N+2, independent of `WAIT_STATES`.
- `Hreadyout` low stalls the master. Address and control presented while low are not sampled and are re-sampled when high.
- Zero-wait burst: one transfer completes per cycle, with no bubble between beats.
- All outputs except `Hrdata` are registered.

## Configuration
- `AHB_SLV_ERR_EN` defined: misses take the two-cycle ERROR response (ERR1/ERR2).
- Not defined:
  - Misses get a zero-wait OKAY; the state machine never enters ERR1/ERR2.
  - Missed writes are discarded.
  - Missed reads return 32'h0.
  - `Hresp` is constant 00.

## Test plan
- **Single write/read:** reset, write 32'h0000_0080 to 32'h8000_0001, then read 32'h8000_0000 (`WAIT_STATES`=0). Read returns 32'h0000_0080; `Hreadyout` never low; `Hresp`=00.
- **Wait states:** `WAIT_STATES`=3, read 32'h8000_0008 after writing 32'hDEAD_BEEF there. `Hreadyout` is low for 3 cycles, then high with `Hrdata`=32'hDEAD_BEEF.
- **Burst:** 4-beat NONSEQ+3 SEQ writes to 32'h8000_0040..4C with data 11,22,33,44, then a 4-beat read burst. Returns 11,22,33,44 on consecutive cycles with no bubbles.
- **Miss with `AHB_SLV_ERR_EN`:** write to 32'h8000_0080. ERR1 shows `Hreadyout`=0/`Hresp`=01; ERR2 shows `Hreadyout`=1/`Hresp`=01; memory unchanged.
- **Miss without `AHB_SLV_ERR_EN`:** read 32'h9000_0000. Zero-wait OKAY with `Hrdata`=0.
- **Reset mid-operation:** assert `Hreset` during WAIT of a write to 32'h8000_0010 with `Hwdata`=32'h1234_5678. After reset, `Hreadyout`=1, `Hresp`=00, and a read of 32'h8000_0010 returns 0.
